countdown_timer: RTL
====================

Name: countdown_timer

Overview:
- HH:MM:SS countdown timer, the down-counting counterpart of the free-running full clock.
- Loads a preset time from switch inputs and decrements once per second to 00:00:00, then flags done.
- Drives the same six active-low seven-segment displays on the MAX 10 board (D1 = seconds units ... D6 = hours tens).
- Internal 1 Hz prescaler with a synchronous BCD borrow chain; no ripple clocks.

Parameters:
- CLK_HZ, 50000000, input clock frequency; prescaler counts 0..CLK_HZ-1 and emits a one-cycle tick at CLK_HZ-1 (sim uses 4).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- preset_h  in  5  preset hours, binary; values >23 saturate to 23
- preset_m  in  6  preset minutes, binary; values >59 saturate to 59
- preset_s  in  6  preset seconds, binary; values >59 saturate to 59
- load  in  1  one-cycle pulse: capture preset, go IDLE
- start_stop  in  1  one-cycle pulse: start / pause / resume
- D1..D6  out  7 each  seven-segment, active-low, bit0=a .. bit6=g; D1 s units, D2 s tens, D3 m units, D4 m tens, D5 h units, D6 h tens
- running  out  1  high in RUN
- done  out  1  high in DONE

Behaviour:
- Reset: state IDLE, all six BCD digits 0, prescaler 0, running=0, done=0, every display shows "0" (7'h40).
- State is held as six BCD digit registers: s_u 0-9, s_t 0-5, m_u 0-9, m_t 0-5, h_u 0-9, h_t 0-2.
- States: IDLE, RUN, PAUSE, DONE.
- load (any state):
  - Binary presets are saturated, then converted to BCD.
  - Digits are written next edge, prescaler clears to 0, state goes IDLE.
  - load has priority over a simultaneous start_stop or tick.
- start_stop:
  - IDLE with time != 0: go RUN and clear the prescaler.
  - IDLE with time == 0: ignored.
  - RUN: go PAUSE; prescaler value is retained.
  - PAUSE: go RUN; prescaler resumes from its held value.
  - DONE: ignored.
- Prescaler:
  - Increments only in RUN.
  - At CLK_HZ-1 it wraps to 0 and asserts tick for exactly one cycle.
  - Held in IDLE, PAUSE and DONE.
  - First decrement occurs CLK_HZ cycles after the start pulse.
- Tick in RUN decrements the time by one second with borrow:
  - s_u 0 -> 9 with borrow into s_t.
  - s_t 0 -> 5 with borrow into m_u.
  - m_u, m_t follow the same pattern.
  - Hours borrow: h_u 0 -> 9 with h_t decrement.
- If the decremented time equals 00:00:00, the state goes DONE on the same edge the digits become zero.
- Simultaneous start_stop and tick in RUN: the tick decrement is applied and the state goes PAUSE.
- DONE: digits stay 00:00:00, done=1; exit only via load or reset.
- running and done are registered and decoded directly from the state register.
- Displays:
  - Combinational decode of the digit registers; each display changes in the same cycle its digit register updates.
  - Codes: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex); unused codes show 7'h7F (blank).
- Reset mid-count: asynchronous return to the reset values; the preset is not retained.

Test Plan:
- Reset then load preset 00:00:03, start, CLK_HZ=4 -> displays 3,2,1,0 at 4-cycle intervals; done=1 and running=0 on the edge showing 0; further start_stop is ignored.
- Load 01:00:00, start, one tick -> D6..D1 show 0,0,5,9,5,9 (00:59:59).
- Load preset_h=31, preset_m=63, preset_s=60 -> displays show 23:59:59.
- RUN, pause at prescaler=2, hold 10 cycles, resume -> next decrement occurs 2 cycles after resume; time is frozen while in PAUSE.
- load and start_stop pulsed in the same cycle while in RUN -> state IDLE, preset loaded, running=0.
- rst_n low mid-count for one cycle, asynchronously -> all displays 7'h40, running=0, done=0 immediately; start_stop afterwards is ignored because time is 0.

Source files
------------

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - HH:MM:SS countdown timer with BCD borrow chain and seven-segment outputs
module countdown_timer #(
  parameter int CLK_HZ = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] preset_h,
  input  logic [5:0] preset_m,
  input  logic [5:0] preset_s,
  input  logic       load,
  input  logic       start_stop,
  output logic [6:0] D1,
  output logic [6:0] D2,
  output logic [6:0] D3,
  output logic [6:0] D4,
  output logic [6:0] D5,
  output logic [6:0] D6,
  output logic       running,
  output logic       done
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state;
  logic [PW-1:0] presc;
  logic [3:0]    s_u, s_t, m_u, m_t, h_u, h_t;
  logic [3:0]    n_s_u, n_s_t, n_m_u, n_m_t, n_h_u, n_h_t;
  logic [4:0]    h_sat;
  logic [5:0]    m_sat, s_sat;
  logic          tick, is_zero, last_sec;

  assign h_sat = (preset_h > 5'd23) ? 5'd23 : preset_h;
  assign m_sat = (preset_m > 6'd59) ? 6'd59 : preset_m;
  assign s_sat = (preset_s > 6'd59) ? 6'd59 : preset_s;

  assign tick     = (state == RUN) && (presc == PRESC_MAX);
  assign is_zero  = ({h_t, h_u, m_t, m_u, s_t, s_u} == 24'd0);
  assign last_sec = ({h_t, h_u, m_t, m_u, s_t} == 20'd0) && (s_u == 4'd1);

  // Borrow chain; only evaluated while running, where the time is never zero.
  always_comb begin
    n_s_u = s_u; n_s_t = s_t; n_m_u = m_u; n_m_t = m_t; n_h_u = h_u; n_h_t = h_t;
    if (s_u != 4'd0) n_s_u = s_u - 4'd1;
    else begin
      n_s_u = 4'd9;
      if (s_t != 4'd0) n_s_t = s_t - 4'd1;
      else begin
        n_s_t = 4'd5;
        if (m_u != 4'd0) n_m_u = m_u - 4'd1;
        else begin
          n_m_u = 4'd9;
          if (m_t != 4'd0) n_m_t = m_t - 4'd1;
          else begin
            n_m_t = 4'd5;
            if (h_u != 4'd0) n_h_u = h_u - 4'd1;
            else begin
              n_h_u = 4'd9;
              n_h_t = h_t - 4'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      presc <= '0;
      {h_t, h_u, m_t, m_u, s_t, s_u} <= 24'd0;
    end else if (load) begin
      state <= IDLE;
      presc <= '0;
      h_t   <= 4'(h_sat / 5'd10);
      h_u   <= 4'(h_sat % 5'd10);
      m_t   <= 4'(m_sat / 6'd10);
      m_u   <= 4'(m_sat % 6'd10);
      s_t   <= 4'(s_sat / 6'd10);
      s_u   <= 4'(s_sat % 6'd10);
    end else begin
      case (state)
        IDLE: begin
          if (start_stop && !is_zero) begin
            state <= RUN;
            presc <= '0;
          end
        end
        RUN: begin
          presc <= tick ? '0 : presc + 1'b1;
          if (tick) {h_t, h_u, m_t, m_u, s_t, s_u} <= {n_h_t, n_h_u, n_m_t, n_m_u, n_s_t, n_s_u};
          if (tick && last_sec) state <= DONE;
          else if (start_stop)  state <= PAUSE;
        end
        PAUSE: begin
          if (start_stop) state <= RUN;
        end
        default: ;
      endcase
    end
  end

  assign running = (state == RUN);
  assign done    = (state == DONE);

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  assign D1 = seg7(s_u);
  assign D2 = seg7(s_t);
  assign D3 = seg7(m_u);
  assign D4 = seg7(m_t);
  assign D5 = seg7(h_u);
  assign D6 = seg7(h_t);

endmodule
